// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the LEGv8 pipeline hazard controller: forwarding selects, controller
// states and the per-stage shadow record (rd/RegWrite/load/memory-access).
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_REG   = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_t;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } ctrl_state_t;

    localparam logic [4:0] XZR = 5'd31;

    typedef struct packed {
        logic [4:0] rd;
        logic       wr;
        logic       ld;
        logic       mem;
    } stage_shadow_t;

    localparam stage_shadow_t SHADOW_RESET = '{rd: XZR, wr: 1'b0, ld: 1'b0, mem: 1'b0};

    // XZR is hardwired zero, so a producer targeting it never creates a dependency.
    function automatic logic src_match(input logic          use_src,
                                       input logic [4:0]    src,
                                       input stage_shadow_t sh);
        return use_src && sh.wr && (sh.rd != XZR) && (sh.rd == src);
    endfunction

endpackage

// File: rtl/stage_shadow.sv
// One pipeline-stage shadow register: holds unless advanced; a clear on an advancing edge
// loads an all-zero (bubble) record.
module stage_shadow
    import pipeline_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          i_advance,
    input  logic          i_clear,
    input  stage_shadow_t i_d,
    output stage_shadow_t o_q
);

    stage_shadow_t r_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= SHADOW_RESET;
        end else if (i_advance) begin
            r_q <= i_clear ? stage_shadow_t'('0) : i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/hazard_controller.sv
// Stall/flush and forwarding-select control for the 5-stage LEGv8 pipeline.
// Define FORWARDING_EN to enable EX-stage forwarding; otherwise any RAW hazard stalls.
module hazard_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned CNT_W   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rn,
    input  logic [4:0] id_rm,
    input  logic       id_useRn,
    input  logic       id_useRm,
    input  logic [4:0] id_rd,
    input  logic       id_regWrite,
    input  logic       id_load,
    input  logic       id_memAccess,
    input  logic       id_brTaken,
    output logic       pc_wrEn,
    output logic       ifid_wrEn,
    output logic       ifid_flush,
    output logic       idex_wrEn,
    output logic       idex_bubble,
    output logic       exmem_wrEn,
    output logic       memwb_wrEn,
    output logic [1:0] fwdA,
    output logic [1:0] fwdB
);

    ctrl_state_t      r_state, w_state_d;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;
    logic             w_adv;
    logic             w_hazard;
    stage_shadow_t    w_id_sh, w_ex, w_mem, w_unused_wb;
    logic             w_unused_bits;

    assign w_id_sh = '{rd: id_rd, wr: id_regWrite, ld: id_load, mem: id_memAccess};
    assign w_adv   = (r_state == RUN);

`ifdef FORWARDING_EN
    assign w_hazard = w_ex.ld && (src_match(id_useRn, id_rn, w_ex) ||
                                  src_match(id_useRm, id_rm, w_ex));
`else
    assign w_hazard = src_match(id_useRn, id_rn, w_ex)  || src_match(id_useRm, id_rm, w_ex) ||
                      src_match(id_useRn, id_rn, w_mem) || src_match(id_useRm, id_rm, w_mem);
`endif

    stage_shadow u_ex_shadow (
        .clk       (clk),
        .reset     (reset),
        .i_advance (w_adv),
        .i_clear   (w_hazard),
        .i_d       (w_id_sh),
        .o_q       (w_ex)
    );

    stage_shadow u_mem_shadow (
        .clk       (clk),
        .reset     (reset),
        .i_advance (w_adv),
        .i_clear   (1'b0),
        .i_d       (w_ex),
        .o_q       (w_mem)
    );

    // WB hazards are covered by the register file's write-before-read.
    stage_shadow u_wb_shadow (
        .clk       (clk),
        .reset     (reset),
        .i_advance (w_adv),
        .i_clear   (1'b0),
        .i_d       (w_mem),
        .o_q       (w_unused_wb)
    );

    assign w_unused_bits = ^{w_mem.ld, w_mem.mem, w_ex.ld};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        unique case (r_state)
            RUN: begin
                // The access moving from EX into MEM on this edge is the one that waits.
                if (w_ex.mem && (MEM_LAT > 1)) begin
                    w_state_d = MEM_WAIT;
                    w_cnt_d   = CNT_W'(MEM_LAT - 1);
                end
            end
            MEM_WAIT: begin
                w_cnt_d = r_cnt - CNT_W'(1);
                if (r_cnt <= CNT_W'(1)) begin
                    w_state_d = RUN;
                    w_cnt_d   = '0;
                end
            end
            default: begin
                w_state_d = RUN;
                w_cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        pc_wrEn     = 1'b1;
        ifid_wrEn   = 1'b1;
        ifid_flush  = 1'b0;
        idex_wrEn   = 1'b1;
        idex_bubble = 1'b0;
        exmem_wrEn  = 1'b1;
        memwb_wrEn  = 1'b1;
        unique case (r_state)
            RUN: begin
                if (w_hazard) begin
                    pc_wrEn     = 1'b0;
                    ifid_wrEn   = 1'b0;
                    idex_bubble = 1'b1;
                end else begin
                    ifid_flush = id_brTaken;
                end
            end
            MEM_WAIT: begin
                pc_wrEn    = 1'b0;
                ifid_wrEn  = 1'b0;
                idex_wrEn  = 1'b0;
                exmem_wrEn = 1'b0;
                memwb_wrEn = 1'b0;
            end
            default: ;
        endcase
    end

`ifdef FORWARDING_EN
    fwd_sel_t r_fwd_a, r_fwd_b, w_fwd_a_d, w_fwd_b_d;

    always_comb begin
        w_fwd_a_d = FWD_REG;
        w_fwd_b_d = FWD_REG;
        if (src_match(id_useRn, id_rn, w_ex)) begin
            w_fwd_a_d = FWD_EXMEM;
        end else if (src_match(id_useRn, id_rn, w_mem)) begin
            w_fwd_a_d = FWD_MEMWB;
        end
        if (src_match(id_useRm, id_rm, w_ex)) begin
            w_fwd_b_d = FWD_EXMEM;
        end else if (src_match(id_useRm, id_rm, w_mem)) begin
            w_fwd_b_d = FWD_MEMWB;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fwd_a <= FWD_REG;
            r_fwd_b <= FWD_REG;
        end else if (w_adv) begin
            r_fwd_a <= w_hazard ? FWD_REG : w_fwd_a_d;
            r_fwd_b <= w_hazard ? FWD_REG : w_fwd_b_d;
        end
    end

    assign fwdA = r_fwd_a;
    assign fwdB = r_fwd_b;
`else
    assign fwdA = FWD_REG;
    assign fwdB = FWD_REG;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: one instance with MEM_LAT=1, one with MEM_LAT=3,
// sharing stimulus. Expectations follow FORWARDING_EN when it is defined.
module tb_hazard_controller;

    localparam logic [6:0] CTL_RUN    = 7'b1101011;
    localparam logic [6:0] CTL_FLUSH  = 7'b1111011;
    localparam logic [6:0] CTL_STALL  = 7'b0001111;
    localparam logic [6:0] CTL_FREEZE = 7'b0000000;

    logic       clk;
    logic       reset;
    logic [4:0] id_rn, id_rm, id_rd;
    logic       id_useRn, id_useRm, id_regWrite, id_load, id_memAccess, id_brTaken;

    logic       pc_wrEn, ifid_wrEn, ifid_flush, idex_wrEn, idex_bubble, exmem_wrEn, memwb_wrEn;
    logic [1:0] fwdA, fwdB;
    logic       pc_wrEn_3, ifid_wrEn_3, ifid_flush_3, idex_wrEn_3, idex_bubble_3;
    logic       exmem_wrEn_3, memwb_wrEn_3;
    logic [1:0] fwdA_3, fwdB_3;
    logic [6:0] ctl, ctl3;

    int n_checks = 0;
    int n_pass   = 0;

    assign ctl  = {pc_wrEn, ifid_wrEn, ifid_flush, idex_wrEn, idex_bubble, exmem_wrEn,
                   memwb_wrEn};
    assign ctl3 = {pc_wrEn_3, ifid_wrEn_3, ifid_flush_3, idex_wrEn_3, idex_bubble_3,
                   exmem_wrEn_3, memwb_wrEn_3};

    hazard_controller #(.MEM_LAT(1), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .id_rn(id_rn), .id_rm(id_rm), .id_useRn(id_useRn), .id_useRm(id_useRm),
        .id_rd(id_rd), .id_regWrite(id_regWrite), .id_load(id_load),
        .id_memAccess(id_memAccess), .id_brTaken(id_brTaken),
        .pc_wrEn(pc_wrEn), .ifid_wrEn(ifid_wrEn), .ifid_flush(ifid_flush),
        .idex_wrEn(idex_wrEn), .idex_bubble(idex_bubble), .exmem_wrEn(exmem_wrEn),
        .memwb_wrEn(memwb_wrEn), .fwdA(fwdA), .fwdB(fwdB)
    );

    hazard_controller #(.MEM_LAT(3), .CNT_W(4)) dut3 (
        .clk(clk), .reset(reset),
        .id_rn(id_rn), .id_rm(id_rm), .id_useRn(id_useRn), .id_useRm(id_useRm),
        .id_rd(id_rd), .id_regWrite(id_regWrite), .id_load(id_load),
        .id_memAccess(id_memAccess), .id_brTaken(id_brTaken),
        .pc_wrEn(pc_wrEn_3), .ifid_wrEn(ifid_wrEn_3), .ifid_flush(ifid_flush_3),
        .idex_wrEn(idex_wrEn_3), .idex_bubble(idex_bubble_3), .exmem_wrEn(exmem_wrEn_3),
        .memwb_wrEn(memwb_wrEn_3), .fwdA(fwdA_3), .fwdB(fwdB_3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] rn, input logic urn, input logic [4:0] rm,
                         input logic urm, input logic [4:0] rd, input logic wr,
                         input logic ld, input logic mem, input logic br);
        id_rn        = rn;
        id_useRn     = urn;
        id_rm        = rm;
        id_useRm     = urm;
        id_rd        = rd;
        id_regWrite  = wr;
        id_load      = ld;
        id_memAccess = mem;
        id_brTaken   = br;
        #1;
    endtask

    task automatic nop();
        drive(5'd31, 1'b0, 5'd31, 1'b0, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        nop();
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        nop();
        n_checks++;
        if (ctl !== CTL_RUN) $display("FAIL reset_ctl: got %b expected %b", ctl, CTL_RUN);
        else n_pass++;
        n_checks++;
        if ({fwdA, fwdB} !== 4'b0000)
            $display("FAIL reset_fwd: got %b expected 0000", {fwdA, fwdB});
        else n_pass++;
        n_checks++;
        if (ctl3 !== CTL_RUN) $display("FAIL reset_ctl3: got %b expected %b", ctl3, CTL_RUN);
        else n_pass++;
        step();
        reset = 1'b0;
        step();
        n_checks++;
        if (ctl !== CTL_RUN) $display("FAIL reset_release: got %b expected %b", ctl, CTL_RUN);
        else n_pass++;
    endtask

    task automatic test_load_use();
        apply_reset();
        drive(5'd5, 1'b1, 5'd31, 1'b0, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0);   // LDUR X1,[X5]
        n_checks++;
        if (ctl !== CTL_RUN) $display("FAIL lu_issue: got %b expected %b", ctl, CTL_RUN);
        else n_pass++;
        step();
        drive(5'd1, 1'b1, 5'd3, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);    // ADD X2,X1,X3
        n_checks++;
        if (ctl !== CTL_STALL) $display("FAIL lu_stall: got %b expected %b", ctl, CTL_STALL);
        else n_pass++;
        step();
        n_checks++;
        if (fwdA !== 2'd0) $display("FAIL lu_fwd_bubble: got %0d expected 0", fwdA);
        else n_pass++;
`ifdef FORWARDING_EN
        n_checks++;
        if (ctl !== CTL_RUN) $display("FAIL lu_release: got %b expected %b", ctl, CTL_RUN);
        else n_pass++;
        step();
        n_checks++;
        if (fwdA !== 2'd2) $display("FAIL lu_fwdA_memwb: got %0d expected 2", fwdA);
        else n_pass++;
        n_checks++;
        if (fwdB !== 2'd0) $display("FAIL lu_fwdB_reg: got %0d expected 0", fwdB);
        else n_pass++;
`else
        n_checks++;
        if (ctl !== CTL_STALL)
            $display("FAIL lu_stall_mem: got %b expected %b", ctl, CTL_STALL);
        else n_pass++;
        step();
        n_checks++;
        if (ctl !== CTL_RUN) $display("FAIL lu_release: got %b expected %b", ctl, CTL_RUN);
        else n_pass++;
        n_checks++;
        if ({fwdA, fwdB} !== 4'b0000)
            $display("FAIL lu_fwd_tied: got %b expected 0000", {fwdA, fwdB});
        else n_pass++;
`endif
    endtask

`ifdef FORWARDING_EN
    task automatic test_back_to_back();
        apply_reset();
        drive(5'd2, 1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);    // ADD X1,X2,X3
        step();
        drive(5'd1, 1'b1, 5'd1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);    // SUB X4,X1,X1
        n_checks++;
        if (ctl !== CTL_RUN) $display("FAIL b2b_no_stall: got %b expected %b", ctl, CTL_RUN);
        else n_pass++;
        step();
        n_checks++;
        if ({fwdA, fwdB} !== 4'b0101)
            $display("FAIL b2b_fwd_exmem: got %b expected 0101", {fwdA, fwdB});
        else n_pass++;
        drive(5'd1, 1'b1, 5'd4, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);    // ADD X5,X1,X4
        step();
        n_checks++;
        if ({fwdA, fwdB} !== 4'b1001)
            $display("FAIL b2b_fwd_mix: got %b expected 1001", {fwdA, fwdB});
        else n_pass++;
        drive(5'd9, 1'b1, 5'd9, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);    // ADD X5,X9,X9
        step();
        drive(5'd5, 1'b1, 5'd5, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);    // X5 in EX and MEM
        step();
        n_checks++;
        if ({fwdA, fwdB} !== 4'b0100)
            $display("FAIL b2b_ex_priority: got %b expected 0100", {fwdA, fwdB});
        else n_pass++;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({fwdA, fwdB} !== 4'b0000)
            $display("FAIL b2b_reset_fwd: got %b expected 0000", {fwdA, fwdB});
        else n_pass++;
        step();
        reset = 1'b0;
        drive(5'd2, 1'b1, 5'd3, 1'b1, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0);   // ADD XZR,X2,X3
        step();
        drive(5'd31, 1'b1, 5'd31, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);  // SUB X4,XZR,XZR
        n_checks++;
        if (ctl !== CTL_RUN) $display("FAIL b2b_xzr_ctl: got %b expected %b", ctl, CTL_RUN);
        else n_pass++;
        step();
        n_checks++;
        if ({fwdA, fwdB} !== 4'b0000)
            $display("FAIL b2b_xzr_fwd: got %b expected 0000", {fwdA, fwdB});
        else n_pass++;
    endtask
`else
    task automatic test_no_forward();
        apply_reset();
        drive(5'd2, 1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);    // ADD X1,X2,X3
        step();
        drive(5'd1, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);    // ADD X2,X1,X1
        n_checks++;
        if (ctl !== CTL_STALL) $display("FAIL nf_stall_ex: got %b expected %b", ctl, CTL_STALL);
        else n_pass++;
        step();
        n_checks++;
        if (ctl !== CTL_STALL)
            $display("FAIL nf_stall_mem: got %b expected %b", ctl, CTL_STALL);
        else n_pass++;
        step();
        n_checks++;
        if (ctl !== CTL_RUN) $display("FAIL nf_release: got %b expected %b", ctl, CTL_RUN);
        else n_pass++;
        n_checks++;
        if ({fwdA, fwdB} !== 4'b0000)
            $display("FAIL nf_fwd_tied: got %b expected 0000", {fwdA, fwdB});
        else n_pass++;
        apply_reset();
        drive(5'd2, 1'b1, 5'd3, 1'b1, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0);   // ADD XZR,X2,X3
        step();
        drive(5'd31, 1'b1, 5'd31, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (ctl !== CTL_RUN) $display("FAIL nf_xzr: got %b expected %b", ctl, CTL_RUN);
        else n_pass++;
        apply_reset();
        drive(5'd2, 1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);    // ADD X1,X2,X3
        step();
        drive(5'd1, 1'b0, 5'd1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);    // X1 fields unused
        n_checks++;
        if (ctl !== CTL_RUN) $display("FAIL nf_use_bit: got %b expected %b", ctl, CTL_RUN);
        else n_pass++;
    endtask
`endif

    task automatic test_branch();
        apply_reset();
        drive(5'd31, 1'b0, 5'd31, 1'b0, 5'd31, 1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (ctl !== CTL_FLUSH) $display("FAIL br_flush: got %b expected %b", ctl, CTL_FLUSH);
        else n_pass++;
        step();
        nop();
        n_checks++;
        if (ctl !== CTL_RUN) $display("FAIL br_one_cycle: got %b expected %b", ctl, CTL_RUN);
        else n_pass++;
        drive(5'd5, 1'b1, 5'd31, 1'b0, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0);   // LDUR X1,[X5]
        step();
        drive(5'd1, 1'b1, 5'd31, 1'b0, 5'd31, 1'b0, 1'b0, 1'b0, 1'b1);  // CBZ X1 taken
        n_checks++;
        if (ctl !== CTL_STALL)
            $display("FAIL br_load_use_stall: got %b expected %b", ctl, CTL_STALL);
        else n_pass++;
        step();
`ifndef FORWARDING_EN
        n_checks++;
        if (ctl !== CTL_STALL)
            $display("FAIL br_stall_mem: got %b expected %b", ctl, CTL_STALL);
        else n_pass++;
        step();
`endif
        n_checks++;
        if (ctl !== CTL_FLUSH)
            $display("FAIL br_flush_after_stall: got %b expected %b", ctl, CTL_FLUSH);
        else n_pass++;
    endtask

    task automatic test_mem_wait();
        apply_reset();
        drive(5'd2, 1'b1, 5'd5, 1'b1, 5'd31, 1'b0, 1'b0, 1'b1, 1'b0);   // STUR X5,[X2]
        n_checks++;
        if (ctl3 !== CTL_RUN) $display("FAIL mw_issue: got %b expected %b", ctl3, CTL_RUN);
        else n_pass++;
        step();
        drive(5'd9, 1'b1, 5'd9, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);    // ADD X1,X9,X9
        n_checks++;
        if (ctl3 !== CTL_RUN)
            $display("FAIL mw_store_in_ex: got %b expected %b", ctl3, CTL_RUN);
        else n_pass++;
        step();
        drive(5'd1, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);    // ADD X6,X1,X1
        n_checks++;
        if (ctl3 !== CTL_FREEZE)
            $display("FAIL mw_wait1: got %b expected %b", ctl3, CTL_FREEZE);
        else n_pass++;
`ifdef FORWARDING_EN
        n_checks++;
        if (ctl !== CTL_RUN) $display("FAIL mw_lat1_no_wait: got %b expected %b", ctl, CTL_RUN);
        else n_pass++;
`else
        n_checks++;
        if (ctl !== CTL_STALL)
            $display("FAIL mw_lat1_no_wait: got %b expected %b", ctl, CTL_STALL);
        else n_pass++;
`endif
        step();
        n_checks++;
        if (ctl3 !== CTL_FREEZE)
            $display("FAIL mw_wait2: got %b expected %b", ctl3, CTL_FREEZE);
        else n_pass++;
        n_checks++;
        if ({fwdA_3, fwdB_3} !== 4'b0000)
            $display("FAIL mw_fwd_hold: got %b expected 0000", {fwdA_3, fwdB_3});
        else n_pass++;
        step();
`ifdef FORWARDING_EN
        n_checks++;
        if (ctl3 !== CTL_RUN) $display("FAIL mw_resume: got %b expected %b", ctl3, CTL_RUN);
        else n_pass++;
        step();
        n_checks++;
        if ({fwdA_3, fwdB_3} !== 4'b0101)
            $display("FAIL mw_ex_shadow_held: got %b expected 0101", {fwdA_3, fwdB_3});
        else n_pass++;
`else
        n_checks++;
        if (ctl3 !== CTL_STALL)
            $display("FAIL mw_resume_stall: got %b expected %b", ctl3, CTL_STALL);
        else n_pass++;
`endif
    endtask

    task automatic test_reset_mid();
        apply_reset();
        drive(5'd2, 1'b1, 5'd5, 1'b1, 5'd31, 1'b0, 1'b0, 1'b1, 1'b0);   // STUR
        step();
        drive(5'd9, 1'b1, 5'd9, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);    // ADD X1,X9,X9
        step();
        n_checks++;
        if (ctl3 !== CTL_FREEZE)
            $display("FAIL rm_wait1: got %b expected %b", ctl3, CTL_FREEZE);
        else n_pass++;
        step();
        reset = 1'b1;
        #1;
        n_checks++;
        if (ctl3 !== CTL_RUN) $display("FAIL rm_wait_reset: got %b expected %b", ctl3, CTL_RUN);
        else n_pass++;
        n_checks++;
        if ({fwdA_3, fwdB_3} !== 4'b0000)
            $display("FAIL rm_wait_reset_fwd: got %b expected 0000", {fwdA_3, fwdB_3});
        else n_pass++;
        step();
        reset = 1'b0;
        step();
        n_checks++;
        if (ctl3 !== CTL_RUN)
            $display("FAIL rm_after_release: got %b expected %b", ctl3, CTL_RUN);
        else n_pass++;
        apply_reset();
        drive(5'd5, 1'b1, 5'd31, 1'b0, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0);   // LDUR X1,[X5]
        step();
        drive(5'd1, 1'b1, 5'd3, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);    // ADD X2,X1,X3
        n_checks++;
        if (ctl !== CTL_STALL) $display("FAIL rm_stall: got %b expected %b", ctl, CTL_STALL);
        else n_pass++;
        reset = 1'b1;
        #1;
        n_checks++;
        if (ctl !== CTL_RUN) $display("FAIL rm_stall_reset: got %b expected %b", ctl, CTL_RUN);
        else n_pass++;
        step();
        reset = 1'b0;
        step();
        n_checks++;
        if (ctl !== CTL_RUN) $display("FAIL rm_no_residual: got %b expected %b", ctl, CTL_RUN);
        else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        nop();
        test_reset();
        test_load_use();
`ifdef FORWARDING_EN
        test_back_to_back();
`else
        test_no_forward();
`endif
        test_branch();
        test_mem_wait();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Owns the stall/flush side of the pipeline register bank: drives every per-stage write enable, the IF/ID flush and the ID/EX bubble.
- Generates registered forwarding selects for the EX stage.
- Keeps its own shadow of destination register, RegWrite, load and memory-access state for the EX, MEM and WB stages.
- Sits beside the decode stage of the 5-stage LEGv8 pipeline.

Parameters:
MEM_LAT, 1, data-memory access latency in cycles (1..15); accesses longer than 1 freeze the pipeline for MEM_LAT-1 cycles
CNT_W, 4, width of the memory-wait counter

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-high reset
id_rn  in  5  decode-stage first source register
id_rm  in  5  decode-stage second source register (post-Reg2Loc mux)
id_useRn  in  1  decode instruction reads id_rn
id_useRm  in  1  decode instruction reads id_rm
id_rd  in  5  decode-stage destination
id_regWrite  in  1  decode instruction writes id_rd
id_load  in  1  decode instruction is a load
id_memAccess  in  1  decode instruction is a load or store
id_brTaken  in  1  branch resolved taken in decode
pc_wrEn  out  1  PC update enable
ifid_wrEn  out  1  IF/ID register wrEn
ifid_flush  out  1  IF/ID loads a NOP this edge
idex_wrEn  out  1  ID/EX register wrEn
idex_bubble  out  1  ID/EX loads all-zero control this edge
exmem_wrEn  out  1  EX/MEM register wrEn
memwb_wrEn  out  1  MEM/WB register wrEn
fwdA  out  2  EX operand A select: 0 reg file, 1 EX/MEM, 2 MEM/WB
fwdB  out  2  EX operand B select, same encoding

Behaviour:
- Reset:
  - state RUN, counter 0, all shadows cleared (wr=0, ld=0, mem=0, rd=31), fwdA=fwdB=0.
  - Combinational outputs then read: all wrEn=1, ifid_flush=0, idex_bubble=0.
- Register 31 (XZR) never matches; a source matches only if its use bit is set and the shadow has wr=1.
- Shadows:
  - On an advancing edge, ID→EX shadow (bubble loads zeros), EX→MEM, MEM→WB.
  - When frozen, all shadows hold.
- State RUN, evaluated in priority order:
  1. Load-use: a used source equals the EX shadow rd with EX ld=1.
     - pc_wrEn=ifid_wrEn=0, idex_bubble=1.
     - EX/MEM and MEM/WB advance.
     - ifid_flush forced 0; the branch is re-evaluated the next cycle.
  2. Otherwise all wrEn=1; ifid_flush=id_brTaken.
- Memory wait:
  - On an advancing edge where the EX shadow has mem=1 and MEM_LAT>1: go to MEM_WAIT, counter=MEM_LAT-1.
- State MEM_WAIT:
  - All wrEn=0, flush=0, bubble=0; counter decrements each cycle.
  - Return to RUN on the edge where counter goes 1→0.
  - Total added latency is exactly MEM_LAT-1 cycles.
- Forwarding selects (registered):
  - Loaded on advancing edges from the decode operands against the pre-edge EX shadow (→1) and MEM shadow (→2); EX has priority.
  - Bubble edge loads 0; freeze holds.
- Reset asserted mid-MEM_WAIT or mid-stall: immediate return to reset values, with no residual bubble.

Optional Feature:
FORWARDING_EN
- Defined: forwarding as above.
- Undefined:
  - fwdA/fwdB tied to 0.
  - Any used source matching the EX or MEM shadow (wr=1, rd≠31) is treated as a load-use stall: same outputs, repeated until no match.
  - The register file's write-before-read covers the WB stage.

Decomposition:
- Package pipeline_ctrl_pkg holds:
  - fwd_sel_t enum (FWD_REG=0, FWD_EXMEM=1, FWD_MEMWB=2)
  - ctrl_state_t enum (RUN, MEM_WAIT)
  - XZR constant 5'd31
  - stage shadow struct {rd, wr, ld, mem}
- Sub-module stage_shadow: one shadow stage register with async reset, advance and clear (bubble) inputs; instantiated three times.

Test Plan:
- Load-use: LDUR X1 in EX, decode ADD X2,X1,X3 → one cycle with pc_wrEn=0, ifid_wrEn=0, idex_bubble=1; next cycle fwdA=2 for the ADD in EX.
- Back-to-back ALU: ADD X1 then SUB X4,X1,X1 → no stall; fwdA=fwdB=1 in SUB's EX cycle. With X31 as destination instead → fwd=0.
- Branch: id_brTaken=1 with no hazard → ifid_flush=1 for one cycle. Same cycle combined with load-use → flush=0 and stall; flush=1 the following cycle.
- MEM_LAT=3, STUR enters MEM → exactly 2 cycles with all wrEn=0, then RUN; no shadow movement during the wait.
- Reset pulse during the 2nd MEM_WAIT cycle → outputs immediately all wrEn=1, fwd=0, state RUN.
- FORWARDING_EN undefined: ADD X1 then ADD X2,X1,X1 → 2 stall cycles (match in EX, then in MEM); fwd remains 0.
